fir_pe_serial: RTL and testbench
================================

# fir_pe_serial

Parametrised digit-serial multiply-accumulate processing element for the systolic FIR array. Each frame it receives a sample X and a partial sum Y as LS-digit-first streams on narrow pads, computes Y + X·C with a double-buffered coefficient C, and streams the result and the forwarded sample to the next PE. Configurable signed/unsigned arithmetic and wrap/saturate modes, plus an overflow flag.

## Interface
- DW, 4: digit (pad) width in bits.
- XW, 8: sample width; XW % DW == 0; NX = XW/DW.
- CW, 8: coefficient width.
- YW, 16: partial-sum width; YW % DW == 0; NY = YW/DW; YW >= XW.
- SIGNED, 0: 0 = unsigned, 1 = two's-complement X, C, Y.
- SAT, 0: 0 = wrap modulo 2^YW, 1 = clamp to YW-bit range.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- coef_in  in  CW  coefficient value.
- coef_ld  in  1  load coef_in into shadow register.
- rdy  in  1  frame start; high only in the cycle of digit 0.
- x_in  in  DW  sample digit, LS first.
- y_in  in  DW  partial-sum digit, LS first.
- x_out  out  DW  forwarded sample digit.
- y_out  out  DW  result digit.
- vld  out  1  pulses with digit 0 of x_out/y_out.
- ovf  out  1  pulses with vld if the result overflowed YW bits.

## Operation
- Frame length is NY cycles. Cycle k (0..NY-1) after rdy carries y_in digit k. x_in digit k is valid for k < NX and is ignored for k >= NX.
- Coefficient: coef_ld captures coef_in into the shadow register. rdy copies shadow to active, so C is fixed for the whole frame. If coef_ld and rdy are high in the same cycle, the new coef_in applies to that frame.
- Input side, FSM IDLE/COLLECT:
  - rdy moves the FSM to COLLECT with cnt=0.
  - The FSM leaves COLLECT after digit NY-1 and raises an internal done pulse.
  - rdy while in COLLECT aborts the partial frame and restarts at cnt=0. Nothing is emitted for the aborted frame.
- Compute: full = X·C + Y, evaluated at width max(XW+CW, YW)+1, sign-extended if SIGNED=1.
  - SAT=0: result = full[YW-1:0]; ovf=1 if full does not fit in YW bits.
  - SAT=1: result clamps to the max/min of the YW-bit range (unsigned: 2^YW-1 or 0); ovf=1 when clamping occurs.
- Output side: an independent NY-digit shift register shifts out LS first. x_out carries X zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to NY digits, aligned with y_out.
- Outside an output frame, x_out, y_out, vld and ovf are 0.
- Output streaming overlaps collection of the next frame. An abort never disturbs an output frame already in progress.

## Timing
- Reset: all registers clear; FSM=IDLE; active C = shadow C = 0; x_out=0, y_out=0, vld=0, ovf=0. Reset during a frame discards both in-flight input and output; the first rdy after release starts cleanly.
- Latency: rdy in cycle t gives vld in cycle t+NY+1. Digit k appears on x_out/y_out in cycle t+NY+1+k.
- Throughput: rdy may repeat every NY cycles (back-to-back frames), giving one result per NY cycles with no bubbles. Consecutive vld pulses are NY cycles apart.
- rdy arriving exactly at cnt=NY-1 is an abort of the current frame, not a back-to-back start.

## Test plan
- Defaults, c=0x12, x=0x34, y=0x0100 → y_out digits 8,A,4,0 (0x04A8); x_out digits 4,3,0,0; vld and ovf=0 in cycle t+5.
- SIGNED=1, x=0xFF, c=0x02, y=0 → 0xFFFE, x_out digits F,F,F,F. Same stimulus with SIGNED=0 → 0x01FE, x_out 0x00FF.
- x=0x7F, c=0x7F, y=0x7FFF, SIGNED=1: SAT=1 → 0x7FFF with ovf=1; SAT=0 → 0xBF00 with ovf=1.
- Back-to-back frames with coef_ld between them: vld every 4 cycles, each result uses the coefficient latched at its own rdy; coef_ld in the same cycle as rdy takes effect immediately.
- rdy at cnt=2, then a full frame → exactly one vld, 5 cycles after the second rdy. An output in progress from an earlier frame completes unchanged.
- Assert reset during output digit 1 → all outputs 0 the same cycle; the next frame after release gives the correct result with C=0 (result = y_in) until a new coef_ld.

Source files
------------

// File: rtl/fir_pe_serial.sv
// Digit-serial multiply-accumulate PE for a systolic FIR array.
// Collects X and Y LS-digit-first, computes Y + X*C with a double-buffered
// coefficient, and streams the result plus the forwarded sample downstream.
module fir_pe_serial #(
  parameter int DW     = 4,
  parameter int XW     = 8,
  parameter int CW     = 8,
  parameter int YW     = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] coef_in,
  input  logic          coef_ld,
  input  logic          rdy,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic          vld,
  output logic          ovf
);

  localparam int NX   = XW / DW;
  localparam int NY   = YW / DW;
  localparam int CNTW = $clog2(NY + 1);
  // Full-precision width: wide enough for X*C + Y with one guard bit.
  localparam int FW   = ((XW + CW > YW) ? (XW + CW) : YW) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            done_reg, done_next;
  logic            take;
  logic [CNTW-1:0] dig;

  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [CW-1:0]   shadow_reg;
  logic [CW-1:0]   coef_reg;

  logic [YW-1:0]   ox_reg;
  logic [YW-1:0]   oy_reg;
  logic            vld_reg;
  logic            ovf_reg;

  logic [FW-1:0]   xe, ce, ye, full;
  logic            x_sgn, c_sgn, y_sgn;
  logic            fits;
  logic [YW-1:0]   result;

  // Input FSM state, digit counter and end-of-collection pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: rdy always (re)starts at digit 0, which also makes a
  // rdy on the last digit an abort rather than a completion.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    take       = rdy || (state_reg == COLLECT);
    dig        = rdy ? '0 : cnt_reg;
    if (take) begin
      if (dig == CNTW'(NY - 1)) begin
        state_next = IDLE;
        cnt_next   = '0;
        done_next  = 1'b1;
      end else begin
        state_next = COLLECT;
        cnt_next   = dig + 1'b1;
      end
    end
  end

  // Operand capture: digits are written into place by index so an aborted
  // frame leaves nothing behind once the next full frame has been collected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (take) begin
      y_reg[dig*DW +: DW] <= y_in;
      if (dig < CNTW'(NX)) begin
        x_reg[dig*DW +: DW] <= x_in;
      end
    end
  end

  // Coefficient double buffer: shadow takes loads, rdy promotes it to active;
  // a load coinciding with rdy bypasses straight to the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg <= '0;
      coef_reg   <= '0;
    end else begin
      if (coef_ld) begin
        shadow_reg <= coef_in;
      end
      if (rdy) begin
        coef_reg <= coef_ld ? coef_in : shadow_reg;
      end
    end
  end

  // Full-precision multiply-accumulate with range check and optional clamp.
  always_comb begin
    x_sgn  = (SIGNED != 0) && x_reg[XW-1];
    c_sgn  = (SIGNED != 0) && coef_reg[CW-1];
    y_sgn  = (SIGNED != 0) && y_reg[YW-1];
    xe     = {{(FW-XW){x_sgn}}, x_reg};
    ce     = {{(FW-CW){c_sgn}}, coef_reg};
    ye     = {{(FW-YW){y_sgn}}, y_reg};
    full   = xe * ce + ye;
    if (SIGNED != 0) begin
      fits = (&full[FW-1:YW-1]) || !(|full[FW-1:YW-1]);
    end else begin
      fits = !(|full[FW-1:YW]);
    end
    result = full[YW-1:0];
    if ((SAT != 0) && !fits) begin
      if (SIGNED != 0) begin
        result = full[FW-1] ? {1'b1, {(YW-1){1'b0}}} : {1'b0, {(YW-1){1'b1}}};
      end else begin
        result = '1;
      end
    end
  end

  // Output shifter: loaded on completion, otherwise shifts zeros in so the
  // pads return to 0 by themselves after the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox_reg  <= '0;
      oy_reg  <= '0;
      vld_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (done_reg) begin
      ox_reg  <= xe[YW-1:0];
      oy_reg  <= result;
      vld_reg <= 1'b1;
      ovf_reg <= !fits;
    end else begin
      ox_reg  <= ox_reg >> DW;
      oy_reg  <= oy_reg >> DW;
      vld_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end
  end

  assign x_out = ox_reg[DW-1:0];
  assign y_out = oy_reg[DW-1:0];
  assign vld   = vld_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_fir_pe_serial.sv
// Self-checking bench for fir_pe_serial: four arithmetic configurations share
// one stimulus stream; expected frames go into a scoreboard queue at rdy and
// are compared when the outputs stream out.
module tb_fir_pe_serial;

  localparam int DW = 4;
  localparam int NX = 2;
  localparam int NY = 4;
  localparam int NV = 9;

  // Per-DUT index: 0 unsigned/wrap, 1 signed/wrap, 2 signed/sat, 3 unsigned/sat
  typedef struct packed {
    logic [3:0][15:0] ey;
    logic [3:0]       eo;
    logic [15:0]      exu;
    logic [15:0]      exs;
    logic [31:0]      cyc;
  } exp_t;

  typedef struct packed {
    logic [7:0]       x;
    logic [7:0]       c;
    logic [15:0]      y;
    logic [3:0][15:0] ey;
    logic [3:0]       eo;
    logic [15:0]      exu;
    logic [15:0]      exs;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] coef_in;
  logic       coef_ld;
  logic       rdy;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic [3:0] x_o [4];
  logic [3:0] y_o [4];
  logic       vld_o [4];
  logic       ovf_o [4];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t vt [NV];

  fir_pe_serial #(.SIGNED(0), .SAT(0)) u0 (.clk(clk), .reset(reset), .coef_in(coef_in), .coef_ld(coef_ld), .rdy(rdy),
    .x_in(x_in), .y_in(y_in), .x_out(x_o[0]), .y_out(y_o[0]), .vld(vld_o[0]), .ovf(ovf_o[0]));
  fir_pe_serial #(.SIGNED(1), .SAT(0)) u1 (.clk(clk), .reset(reset), .coef_in(coef_in), .coef_ld(coef_ld), .rdy(rdy),
    .x_in(x_in), .y_in(y_in), .x_out(x_o[1]), .y_out(y_o[1]), .vld(vld_o[1]), .ovf(ovf_o[1]));
  fir_pe_serial #(.SIGNED(1), .SAT(1)) u2 (.clk(clk), .reset(reset), .coef_in(coef_in), .coef_ld(coef_ld), .rdy(rdy),
    .x_in(x_in), .y_in(y_in), .x_out(x_o[2]), .y_out(y_o[2]), .vld(vld_o[2]), .ovf(ovf_o[2]));
  fir_pe_serial #(.SIGNED(0), .SAT(1)) u3 (.clk(clk), .reset(reset), .coef_in(coef_in), .coef_ld(coef_ld), .rdy(rdy),
    .x_in(x_in), .y_in(y_in), .x_out(x_o[3]), .y_out(y_o[3]), .vld(vld_o[3]), .ovf(ovf_o[3]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] x, input logic [7:0] c, input logic [15:0] y,
                              input logic [15:0] e0, input logic o0, input logic [15:0] e1, input logic o1,
                              input logic [15:0] e2, input logic o2, input logic [15:0] e3, input logic o3,
                              input logic [15:0] exu, input logic [15:0] exs);
    vec_t v;
    v.x = x; v.c = c; v.y = y;
    v.ey = {e3, e2, e1, e0};
    v.eo = {o3, o2, o1, o0};
    v.exu = exu; v.exs = exs;
    return v;
  endfunction

  function automatic exp_t e_vec(input vec_t v);
    exp_t e;
    e.ey = v.ey; e.eo = v.eo; e.exu = v.exu; e.exs = v.exs; e.cyc = '0;
    return e;
  endfunction

  function automatic exp_t e_all(input logic [15:0] y, input logic [15:0] x);
    exp_t e;
    e.ey = {y, y, y, y}; e.eo = '0; e.exu = x; e.exs = x; e.cyc = '0;
    return e;
  endfunction

  // Drive nd digits of a frame starting with rdy; push the expectation at rdy.
  task automatic send_frame(input logic [7:0] x, input logic [15:0] y, input logic ld0, input logic [7:0] c0,
                            input logic ld2, input logic [7:0] c2, input int nd, input logic push, input exp_t e);
    for (int k = 0; k < nd; k++) begin
      @(posedge clk); #1;
      rdy     = (k == 0);
      x_in    = (k < NX) ? x[k*DW +: DW] : 4'($urandom);
      y_in    = y[k*DW +: DW];
      coef_ld = (k == 0 && ld0) || (k == 2 && ld2);
      coef_in = (k == 0) ? c0 : ((k == 2) ? c2 : 8'($urandom));
      if (k == 0 && push) begin
        e.cyc = 32'(cyc + NY + 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rdy = 1'b0; coef_ld = 1'b0;
      x_in = 4'($urandom); y_in = 4'($urandom); coef_in = 8'($urandom);
    end
  endtask

  // Output monitor: assembles each frame's digits and checks it against the scoreboard.
  int          cap_n = 0;
  exp_t        cur;
  logic [15:0] ycap [4];
  logic [15:0] xcap [4];
  always @(negedge clk) begin
    if (reset) begin
      cap_n = 0;
      sb.delete();
    end else if (vld_o[0] || vld_o[1] || vld_o[2] || vld_o[3]) begin
      chk("vld_inside_frame", 32'(cap_n), 32'd0);
      for (int d = 0; d < 4; d++) chk($sformatf("vld_dut%0d", d), 32'(vld_o[d]), 32'd1);
      chk("unexpected_vld", 32'(sb.size() > 0), 32'd1);
      cap_n = 0;
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk("vld_cycle", 32'(cyc), cur.cyc);
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("ovf_dut%0d", d), 32'(ovf_o[d]), 32'(cur.eo[d]));
          ycap[d] = '0; xcap[d] = '0;
          ycap[d][3:0] = y_o[d];
          xcap[d][3:0] = x_o[d];
        end
        cap_n = 1;
      end
    end else if (cap_n > 0) begin
      for (int d = 0; d < 4; d++) begin
        ycap[d][cap_n*DW +: DW] = y_o[d];
        xcap[d][cap_n*DW +: DW] = x_o[d];
        chk($sformatf("ovf_mid_dut%0d", d), 32'(ovf_o[d]), 32'd0);
      end
      cap_n++;
      if (cap_n == NY) begin
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("y_dut%0d", d), 32'(ycap[d]), 32'(cur.ey[d]));
          chk($sformatf("x_dut%0d", d), 32'(xcap[d]), 32'((d == 1 || d == 2) ? cur.exs : cur.exu));
        end
        $display("frame cycle=%0d y=%h %h %h %h x=%h %h ovf=%b%b%b%b", cur.cyc,
                 ycap[0], ycap[1], ycap[2], ycap[3], xcap[0], xcap[1],
                 ovf_o[0], ovf_o[1], ovf_o[2], ovf_o[3]);
        cap_n = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++)
        chk($sformatf("idle_zero_dut%0d", d), 32'({x_o[d], y_o[d], ovf_o[d]}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           x      c      y        uwrap     swrap     ssat      usat      exu       exs
    vt[0] = mk(8'h34, 8'h12, 16'h0100, 16'h04A8, 0, 16'h04A8, 0, 16'h04A8, 0, 16'h04A8, 0, 16'h0034, 16'h0034);
    vt[1] = mk(8'hFF, 8'h02, 16'h0000, 16'h01FE, 0, 16'hFFFE, 0, 16'hFFFE, 0, 16'h01FE, 0, 16'h00FF, 16'hFFFF);
    vt[2] = mk(8'h7F, 8'h7F, 16'h7FFF, 16'hBF00, 0, 16'hBF00, 1, 16'h7FFF, 1, 16'hBF00, 0, 16'h007F, 16'h007F);
    vt[3] = mk(8'hFF, 8'hFF, 16'hFFFF, 16'hFE00, 1, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 16'h00FF, 16'hFFFF);
    vt[4] = mk(8'h80, 8'h7F, 16'h8000, 16'hBF80, 0, 16'h4080, 1, 16'h8000, 1, 16'hBF80, 0, 16'h0080, 16'hFF80);
    vt[5] = mk(8'h00, 8'h55, 16'h1234, 16'h1234, 0, 16'h1234, 0, 16'h1234, 0, 16'h1234, 0, 16'h0000, 16'h0000);
    vt[6] = mk(8'h10, 8'h10, 16'hFF00, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 16'h0010, 16'h0010);
    vt[7] = mk(8'hFE, 8'h01, 16'h0001, 16'h00FF, 0, 16'hFFFF, 0, 16'hFFFF, 0, 16'h00FF, 0, 16'h00FE, 16'hFFFE);
    vt[8] = mk(8'h03, 8'hFE, 16'h0000, 16'h02FA, 0, 16'hFFFA, 0, 16'hFFFA, 0, 16'h02FA, 0, 16'h0003, 16'h0003);

    reset = 1'b1; rdy = 1'b0; coef_ld = 1'b0; coef_in = '0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("reset_outputs_dut%0d", d), 32'({x_o[d], y_o[d], vld_o[d], ovf_o[d]}), 32'd0);
    reset = 1'b0;
    idle(2);

    // Back-to-back table frames; even frames load their own C at rdy and the
    // next frame's C mid-frame, odd frames take C from the shadow register.
    for (int i = 0; i < NV; i++) begin
      send_frame(vt[i].x, vt[i].y, (i % 2 == 0), vt[i].c,
                 (i % 2 == 0) && (i + 1 < NV), vt[(i + 1 < NV) ? i + 1 : i].c,
                 NY, 1'b1, e_vec(vt[i]));
    end
    idle(8);

    // Aborts: at cnt=2 while the previous output streams, then at cnt=NY-1.
    send_frame(8'h34, 16'h0100, 1'b1, 8'h12, 1'b0, 8'h00, NY, 1'b1, e_all(16'h04A8, 16'h0034));
    send_frame(8'hAA, 16'hBBBB, 1'b1, 8'h77, 1'b0, 8'h00, 2, 1'b0, e_all(16'h0000, 16'h0000));
    send_frame(8'h05, 16'h0010, 1'b1, 8'h03, 1'b0, 8'h00, NY, 1'b1, e_all(16'h001F, 16'h0005));
    send_frame(8'hAA, 16'hCCCC, 1'b0, 8'h00, 1'b0, 8'h00, 3, 1'b0, e_all(16'h0000, 16'h0000));
    send_frame(8'h05, 16'h0020, 1'b0, 8'h00, 1'b0, 8'h00, NY, 1'b1, e_all(16'h002F, 16'h0005));
    idle(10);

    // Reset during output digit 1, then a frame with C cleared, then a reload.
    send_frame(8'h02, 16'h0001, 1'b1, 8'h03, 1'b0, 8'h00, NY, 1'b1, e_all(16'h0007, 16'h0002));
    idle(2);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("async_reset_dut%0d", d), 32'({x_o[d], y_o[d], vld_o[d], ovf_o[d]}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    send_frame(8'h44, 16'h1357, 1'b0, 8'h00, 1'b0, 8'h00, NY, 1'b1, e_all(16'h1357, 16'h0044));
    idle(6);
    send_frame(8'h02, 16'h0001, 1'b1, 8'h03, 1'b0, 8'h00, NY, 1'b1, e_all(16'h0007, 16'h0002));
    idle(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
